// File: rtl/fpu_issue_pkg.sv
// Shared widths, FSM encoding and operation payload for the FPU issue stage.
package fpu_issue_pkg;

    localparam int unsigned FUNC3_W = 3;
    localparam int unsigned FUNC7_W = 7;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] ST_HOLD  = 2'd3;

    // Commonly used func7 selectors
    localparam logic [FUNC7_W-1:0] FUNC7_FADD  = 7'b0000000;
    localparam logic [FUNC7_W-1:0] FUNC7_FSQRT = 7'b0101100;
    localparam logic [FUNC7_W-1:0] FUNC7_FMVI  = 7'b1111000;

    typedef struct packed {
        logic [FUNC3_W-1:0] func3;
        logic [FUNC7_W-1:0] func7;
        logic [WORD_W-1:0]  rs1;
        logic [WORD_W-1:0]  rs2;
    } fpu_op_t;

endpackage

// File: rtl/fpu_issue.sv
// Issues one decoded FP operation to an FPU, waits for its result (with timeout)
// and holds the result until writeback consumes it.
module fpu_issue
    import fpu_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TAG_W          = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNC3_W-1:0] in_func3,
    input  logic [FUNC7_W-1:0] in_func7,
    input  logic [WORD_W-1:0]  in_rs1,
    input  logic [WORD_W-1:0]  in_rs2,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               order,
    input  logic               accepted,
    input  logic               done,
    output logic [FUNC3_W-1:0] func3,
    output logic [FUNC7_W-1:0] func7,
    output logic [WORD_W-1:0]  rs1,
    output logic [WORD_W-1:0]  rs2,
    input  logic [WORD_W-1:0]  rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_n;
    fpu_op_t            op;
    logic [TIMER_W-1:0] timer;
    logic               load;
    logic               capture;
    logic               expire;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, datapath strobes and state-decoded handshakes
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        in_ready  = 1'b0;
        order     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                order = 1'b1;
                // done wins over both accept and timeout in the same cycle
                if (done) begin
                    capture = 1'b1;
                    state_n = ST_HOLD;
                end else if (timer == TIMER_LAST) begin
                    expire  = 1'b1;
                    state_n = ST_HOLD;
                end else if (accepted) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    capture = 1'b1;
                    state_n = ST_HOLD;
                end else if (timer == TIMER_LAST) begin
                    expire  = 1'b1;
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Operand latch, timer and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op       <= '0;
            out_tag  <= '0;
            timer    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            if (load) begin
                op      <= '{func3: in_func3, func7: in_func7, rs1: in_rs1, rs2: in_rs2};
                out_tag <= in_tag;
                timer   <= '0;
            end else if ((state == ST_ISSUE || state == ST_WAIT) && timer != TIMER_MAX) begin
                timer <= timer + TIMER_W'(1);
            end
            if (capture) begin
                out_data <= rd;
                out_err  <= 1'b0;
            end else if (expire) begin
                out_data <= '0;
                out_err  <= 1'b1;
            end
        end
    end

    assign func3 = op.func3;
    assign func7 = op.func7;
    assign rs1   = op.rs1;
    assign rs2   = op.rs2;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed self-checking bench for fpu_issue with a short timeout.
module tb_fpu_issue;
    import fpu_issue_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        order;
    logic        accepted;
    logic        done;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic        busy;

    int n_checks;
    int n_fails;

    fpu_issue #(.TIMEOUT_CYCLES(8), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_func3(in_func3), .in_func7(in_func7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .order(order), .accepted(accepted), .done(done),
        .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single handshake cycle; returns in ISSUE
    task automatic send(input string name, input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        check({name, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_func3 = 3'd0;
        in_func7 = f7;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        in_rs1   = 32'hFFFF_FFFF;
        in_rs2   = 32'hFFFF_FFFF;
    endtask

    // Full operation: accepted after acc_dly extra ISSUE cycles, done done_dly cycles after accept
    task automatic do_op(input string name, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input int acc_dly, input int done_dly, input logic [31:0] res);
        send(name, f7, a, b, tag);
        for (int i = 0; i < acc_dly; i++) begin
            check({name, ":order_held"}, 32'(order), 32'd1);
            check({name, ":rs1_issue"}, rs1, a);
            tick();
        end
        check({name, ":order"}, 32'(order), 32'd1);
        check({name, ":func7"}, 32'(func7), 32'(f7));
        check({name, ":rs2_issue"}, rs2, b);
        accepted = 1'b1;
        if (done_dly == 0) begin
            done = 1'b1;
            rd   = res;
        end
        tick();
        accepted = 1'b0;
        done     = 1'b0;
        for (int i = 1; i <= done_dly; i++) begin
            check({name, ":order_wait"}, 32'(order), 32'd0);
            check({name, ":rs1_wait"}, rs1, a);
            check({name, ":rs2_wait"}, rs2, b);
            check({name, ":out_valid_wait"}, 32'(out_valid), 32'd0);
            if (i == done_dly) begin
                done = 1'b1;
                rd   = res;
            end
            tick();
            done = 1'b0;
        end
        check({name, ":out_valid"}, 32'(out_valid), 32'd1);
        check({name, ":order_hold"}, 32'(order), 32'd0);
        check({name, ":out_data"}, out_data, res);
        check({name, ":out_err"}, 32'(out_err), 32'd0);
        check({name, ":out_tag"}, 32'(out_tag), 32'(tag));
        rd = 32'h0BAD_0BAD;
    endtask

    task automatic release_hold(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ":out_valid_rel"}, 32'(out_valid), 32'd0);
        check({name, ":in_ready_rel"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_func3  = '0;
        in_func7  = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        accepted  = 1'b0;
        done      = 1'b0;
        rd        = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst:order", 32'(order), 32'd0);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:out_data", out_data, 32'd0);
        check("rst:out_tag", 32'(out_tag), 32'd0);
        check("rst:out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        tick();
        check("rst:in_ready", 32'(in_ready), 32'd1);

        // Stray FPU strobes in IDLE are ignored
        accepted = 1'b1;
        done     = 1'b1;
        rd       = 32'h1234_5678;
        tick();
        accepted = 1'b0;
        done     = 1'b0;
        check("idle_stray:busy", 32'(busy), 32'd0);
        check("idle_stray:order", 32'(order), 32'd0);
        check("idle_stray:out_data", out_data, 32'd0);

        do_op("fmvi", FUNC7_FMVI, 32'h3F80_0000, 32'h0, 5'd3, 0, 0, 32'h3F80_0000);
        release_hold("fmvi");

        do_op("fadd", FUNC7_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd7, 0, 4, 32'h4040_0000);
        release_hold("fadd");

        do_op("dlyacc", FUNC7_FADD, 32'h4000_0000, 32'h4000_0000, 5'd12, 3, 1, 32'h4080_0000);

        // Backpressure with a pending new request and stray strobes in HOLD
        in_valid = 1'b1;
        in_func7 = FUNC7_FMVI;
        in_rs1   = 32'hC000_0000;
        in_rs2   = 32'h0;
        in_tag   = 5'd21;
        for (int i = 0; i < 5; i++) begin
            accepted = 1'b1;
            done     = 1'b1;
            rd       = 32'hDEAD_BEEF;
            check("bp:out_valid", 32'(out_valid), 32'd1);
            check("bp:in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp:out_data", out_data, 32'h4080_0000);
            check("bp:out_tag", 32'(out_tag), 32'd12);
        end
        accepted  = 1'b0;
        done      = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp:idle_busy", 32'(busy), 32'd0);
        check("bp:idle_order", 32'(order), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp:new_order", 32'(order), 32'd1);
        check("bp:new_rs1", rs1, 32'hC000_0000);
        accepted = 1'b1;
        done     = 1'b1;
        rd       = 32'hC000_0000;
        tick();
        accepted = 1'b0;
        done     = 1'b0;
        check("bp:new_out_data", out_data, 32'hC000_0000);
        check("bp:new_out_tag", 32'(out_tag), 32'd21);
        release_hold("bp");

        // Timeout: accepted, never done; HOLD reached after 8 ISSUE/WAIT cycles
        send("tmo", FUNC7_FADD, 32'h3F80_0000, 32'h3F80_0000, 5'd9);
        check("tmo:order", 32'(order), 32'd1);
        accepted = 1'b1;
        tick();
        accepted = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("tmo:busy_wait", 32'(busy), 32'd1);
            check("tmo:out_valid_wait", 32'(out_valid), 32'd0);
            tick();
        end
        check("tmo:out_valid", 32'(out_valid), 32'd1);
        check("tmo:out_err", 32'(out_err), 32'd1);
        check("tmo:out_data", out_data, 32'd0);
        check("tmo:out_tag", 32'(out_tag), 32'd9);
        done = 1'b1;
        rd   = 32'hDEAD_BEEF;
        tick();
        done = 1'b0;
        check("tmo:stray_data", out_data, 32'd0);
        check("tmo:stray_err", 32'(out_err), 32'd1);
        check("tmo:stray_valid", 32'(out_valid), 32'd1);
        release_hold("tmo");

        // Asynchronous reset during WAIT
        send("arst", FUNC7_FADD, 32'h4000_0000, 32'h3F80_0000, 5'd5);
        accepted = 1'b1;
        tick();
        accepted = 1'b0;
        check("arst:busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst:order", 32'(order), 32'd0);
        check("arst:out_valid", 32'(out_valid), 32'd0);
        check("arst:busy", 32'(busy), 32'd0);
        check("arst:out_tag", 32'(out_tag), 32'd0);
        tick();
        rst  = 1'b0;
        done = 1'b1;
        rd   = 32'h1111_1111;
        tick();
        done = 1'b0;
        check("arst:late_done_busy", 32'(busy), 32'd0);
        check("arst:late_done_data", out_data, 32'd0);
        do_op("fsqrt", FUNC7_FSQRT, 32'h4080_0000, 32'h0, 5'd30, 0, 2, 32'h4000_0000);
        release_hold("fsqrt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
